bus_mem_responder: RTL and testbench

- Responder end of the cache-to-memory line bus: it services line reads (fetch) and line writes (write-back) issued by the cache controller.
- It holds 2^ADDR_W lines of DATA_W bits each, with a programmable access latency and a one-cycle done pulse.
- It replaces the behavioural memory model in cache benches and is synthesizable.
- It adds protocol-error flagging and access counters for coverage.

---
 rtl/bus_mem_pkg.sv | 18 +
 rtl/mem_lat_timer.sv | 28 ++
 rtl/bus_mem_responder.sv | 118 +++++++++++
 tb/tb_bus_mem_responder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_mem_pkg.sv
// Shared constants for the cache-to-memory line bus responder: state codes,
// default widths and the saturating counter helper.
package bus_mem_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 16;
    localparam int COUNT_W    = 16;
    localparam int LAT_W      = 4;

    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_BUSY = 3'b010;
    localparam logic [2:0] S_DONE = 3'b100;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter that measures out the access latency; o_zero marks
// the edge on which the access completes.
module mem_lat_timer #(
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [LAT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [LAT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/bus_mem_responder.sv
// Memory end of the cache line bus: one access at a time, fixed latency,
// one-cycle done pulse, protocol-error flag and saturating access counters.
module bus_mem_responder
  import bus_mem_pkg::*;
#(
  parameter int    ADDR_W    = DEF_ADDR_W,
  parameter int    DATA_W    = DEF_DATA_W,
  parameter int    LATENCY   = 4,
  parameter string INIT_FILE = "datamem.txt"
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               memread,
  input  logic               memwrite,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata,
  output logic               mem_done,
  output logic               mem_err,
  output logic [COUNT_W-1:0] rd_count,
  output logic [COUNT_W-1:0] wr_count,
  output logic [2:0]         dbg_state
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [LAT_W-1:0]  LOAD_VAL = LAT_W'(LATENCY - 1);

  // Request handshake: memread/memwrite are levels sampled only in IDLE;
  // the initiator must drop or change them on the edge it sees mem_done=1.
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [2:0]         r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_is_wr;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_err;
  logic [COUNT_W-1:0] r_rd_count;
  logic [COUNT_W-1:0] r_wr_count;

  logic w_req;
  logic w_accept;
  logic w_busy;
  logic w_zero;
  logic w_finish;

  assign w_req    = memread | memwrite;
  assign w_accept = (r_state == S_IDLE) && w_req;
  assign w_busy   = (r_state == S_BUSY);
  assign w_finish = w_busy && w_zero;

  mem_lat_timer #(
    .LAT_W(LAT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_busy),
    .o_zero     (w_zero)
  );

  // The array has no reset; a reset in flight simply suppresses the commit.
  always_ff @(posedge clk) begin
    if (rst && w_finish && r_is_wr) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_wr    <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      r_err <= w_accept && memread && memwrite;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_state <= S_BUSY;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_is_wr <= memwrite;
          end
        end
        S_BUSY: begin
          if (w_zero) begin
            r_state <= S_DONE;
            if (!r_is_wr) begin
              r_rdata <= r_mem[r_addr];
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          if (r_is_wr) begin
            r_wr_count <= sat_inc(r_wr_count);
          end else begin
            r_rd_count <= sat_inc(r_rd_count);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rdata     = r_rdata;
  assign mem_done  = (r_state == S_DONE);
  assign mem_err   = r_err;
  assign rd_count  = r_rd_count;
  assign wr_count  = r_wr_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: two instances (latency 4 and latency 1) checked
// against an array-and-counter reference model.
module tb_bus_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d4_rst = 1'b0, d4_rd = 1'b0, d4_wr = 1'b0;
  logic [4:0]  d4_addr = '0;
  logic [15:0] d4_wdata = '0;
  logic [15:0] d4_rdata, d4_rdc, d4_wrc;
  logic        d4_done, d4_err;
  logic [2:0]  d4_state;

  logic        d1_rst = 1'b0, d1_rd = 1'b0, d1_wr = 1'b0;
  logic [4:0]  d1_addr = '0;
  logic [15:0] d1_wdata = '0;
  logic [15:0] d1_rdata, d1_rdc, d1_wrc;
  logic        d1_done, d1_err;
  logic [2:0]  d1_state;

  bus_mem_responder #(.ADDR_W(5), .DATA_W(16), .LATENCY(4), .INIT_FILE("")) dut4 (
    .clk(clk), .rst(d4_rst), .addr(d4_addr), .memread(d4_rd), .memwrite(d4_wr),
    .wdata(d4_wdata), .rdata(d4_rdata), .mem_done(d4_done), .mem_err(d4_err),
    .rd_count(d4_rdc), .wr_count(d4_wrc), .dbg_state(d4_state)
  );

  bus_mem_responder #(.ADDR_W(5), .DATA_W(16), .LATENCY(1), .INIT_FILE("")) dut1 (
    .clk(clk), .rst(d1_rst), .addr(d1_addr), .memread(d1_rd), .memwrite(d1_wr),
    .wdata(d1_wdata), .rdata(d1_rdata), .mem_done(d1_done), .mem_err(d1_err),
    .rd_count(d1_rdc), .wr_count(d1_wrc), .dbg_state(d1_state)
  );

  int tests = 0;
  int fails = 0;

  // reference model, indexed by instance (0 = latency 4, 1 = latency 1)
  logic [15:0] exp_mem [0:1][0:31];
  logic [15:0] exp_rdata [0:1];
  int          exp_rd [0:1];
  int          exp_wr [0:1];

  function automatic int lat_of(input int sel);
    return (sel == 1) ? 1 : 4;
  endfunction

  function automatic logic [15:0] image_word(input int k);
    logic [7:0] lo, hi;
    lo = 8'(2 * k);
    hi = 8'(2 * k + 1);
    return {hi, lo};
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 1) ? d1_done : d4_done;
  endfunction

  function automatic logic get_err(input int sel);
    return (sel == 1) ? d1_err : d4_err;
  endfunction

  function automatic logic [15:0] get_rdata(input int sel);
    return (sel == 1) ? d1_rdata : d4_rdata;
  endfunction

  function automatic logic [15:0] get_rdc(input int sel);
    return (sel == 1) ? d1_rdc : d4_rdc;
  endfunction

  function automatic logic [15:0] get_wrc(input int sel);
    return (sel == 1) ? d1_wrc : d4_wrc;
  endfunction

  function automatic logic [2:0] get_state(input int sel);
    return (sel == 1) ? d1_state : d4_state;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input bit rd, input bit wr,
                       input logic [4:0] a, input logic [15:0] d);
    if (sel == 1) begin
      d1_rd = rd; d1_wr = wr; d1_addr = a; d1_wdata = d;
    end else begin
      d4_rd = rd; d4_wr = wr; d4_addr = a; d4_wdata = d;
    end
  endtask

  task automatic set_rst(input int sel, input logic v);
    if (sel == 1) d1_rst = v;
    else d4_rst = v;
  endtask

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_op(input int sel, input bit rd, input bit wr,
                          input logic [4:0] a, input logic [15:0] d);
    if (wr) begin
      exp_mem[sel][a] = d;
      exp_wr[sel] = sat(exp_wr[sel] + 1);
    end else if (rd) begin
      exp_rdata[sel] = exp_mem[sel][a];
      exp_rd[sel] = sat(exp_rd[sel] + 1);
    end
  endtask

  task automatic model_reset(input int sel);
    exp_rd[sel] = 0;
    exp_wr[sel] = 0;
    exp_rdata[sel] = 16'h0000;
  endtask

  task automatic pulse_reset(input int sel);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 5'd0, 16'h0);
    set_rst(sel, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_rst(sel, 1'b1);
    model_reset(sel);
  endtask

  // mode 0: drop request after done; 1: hold it one cycle too long;
  // 2: switch straight to a second request when done is seen.
  task automatic access(input int sel, input bit rd, input bit wr,
                        input logic [4:0] a, input logic [15:0] d, input int mode,
                        input bit rd2, input bit wr2, input logic [4:0] a2,
                        input logic [15:0] d2,
                        output int lat, output int pulses, output int gap, output int errs);
    int cyc;
    @(negedge clk);
    drive(sel, rd, wr, a, d);
    cyc = 0; lat = -1; pulses = 0; gap = -1; errs = 0;
    while (lat < 0 && cyc < 40) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (get_err(sel)) errs++;
      if (get_done(sel)) begin
        lat = cyc - 1;
        pulses = 1;
      end
    end
    if (mode == 0) drive(sel, 1'b0, 1'b0, 5'd0, 16'h0);
    else if (mode == 2) drive(sel, rd2, wr2, a2, d2);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (get_err(sel)) errs++;
      if (get_done(sel)) begin
        pulses++;
        if (gap < 0) gap = i;
      end
      if (i == 2) drive(sel, 1'b0, 1'b0, 5'd0, 16'h0);
    end
  endtask

  task automatic check_state(input int sel, input string tag);
    check({tag, ".rdata"}, 32'(get_rdata(sel)), 32'(exp_rdata[sel]));
    check({tag, ".rd_count"}, 32'(get_rdc(sel)), 32'(exp_rd[sel]));
    check({tag, ".wr_count"}, 32'(get_wrc(sel)), 32'(exp_wr[sel]));
  endtask

  task automatic do_op(input int sel, input bit rd, input bit wr,
                       input logic [4:0] a, input logic [15:0] d, input string tag);
    int lat, pulses, gap, errs;
    access(sel, rd, wr, a, d, 0, 1'b0, 1'b0, 5'd0, 16'h0, lat, pulses, gap, errs);
    model_op(sel, rd, wr, a, d);
    check({tag, ".latency"}, 32'(lat), 32'(lat_of(sel)));
    check({tag, ".done_pulses"}, 32'(pulses), 32'd1);
    check({tag, ".err_pulses"}, 32'(errs), (rd && wr) ? 32'd1 : 32'd0);
    check_state(sel, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, pulses, gap, errs, cnt;
    bit rd, wr;
    logic [4:0] a;
    logic [15:0] d;

    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 32; k++) exp_mem[s][k] = 16'hxxxx;
      model_reset(s);
    end

    // reset state of both instances
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset.done", 32'(get_done(s)), 32'd0);
      check("reset.err", 32'(get_err(s)), 32'd0);
      check("reset.state", 32'(get_state(s)), 32'd1);
      check_state(s, "reset");
    end
    d4_rst = 1'b1;
    d1_rst = 1'b1;

    // load the image {2k+1, 2k} through the bus, then reset the counters
    for (int k = 0; k < 32; k++) do_op(0, 1'b0, 1'b1, 5'(k), image_word(k), "preload4");
    pulse_reset(0);
    @(negedge clk);
    check("rst4.state", 32'(d4_state), 32'd1);
    check_state(0, "rst4");

    do_op(0, 1'b1, 1'b0, 5'd0, 16'h0, "read0");
    check("read0.value", 32'(d4_rdata), 32'h0100);

    // write-back followed immediately by a fetch of the same line
    access(0, 1'b0, 1'b1, 5'd4, 16'h0d08, 2, 1'b1, 1'b0, 5'd4, 16'h0, lat, pulses, gap, errs);
    model_op(0, 1'b0, 1'b1, 5'd4, 16'h0d08);
    model_op(0, 1'b1, 1'b0, 5'd4, 16'h0);
    check("wb_fetch.latency", 32'(lat), 32'd4);
    check("wb_fetch.pulses", 32'(pulses), 32'd2);
    check("wb_fetch.gap", 32'(gap), 32'(lat_of(0) + 2));
    check("wb_fetch.value", 32'(d4_rdata), 32'h0d08);
    check_state(0, "wb_fetch");

    // request held one cycle past done is taken as a second read
    access(0, 1'b1, 1'b0, 5'd1, 16'h0, 1, 1'b0, 1'b0, 5'd0, 16'h0, lat, pulses, gap, errs);
    model_op(0, 1'b1, 1'b0, 5'd1, 16'h0);
    model_op(0, 1'b1, 1'b0, 5'd1, 16'h0);
    check("late_drop.pulses", 32'(pulses), 32'd2);
    check("late_drop.gap", 32'(gap), 32'(lat_of(0) + 2));
    check_state(0, "late_drop");

    // both strobes: write wins, error pulses once
    do_op(0, 1'b1, 1'b1, 5'd6, 16'h1111, "both");
    do_op(0, 1'b1, 1'b0, 5'd6, 16'h0, "both_rb");
    check("both_rb.value", 32'(d4_rdata), 32'h1111);

    // reset in the middle of a write aborts it
    pulse_reset(0);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 5'd2, 16'hffff);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("abort.busy_state", 32'(d4_state), 32'd2);
    d4_rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    d4_rst = 1'b1;
    drive(0, 1'b0, 1'b0, 5'd0, 16'h0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (d4_done) cnt++;
    end
    check("abort.done_pulses", 32'(cnt), 32'd0);
    check_state(0, "abort");
    do_op(0, 1'b1, 1'b0, 5'd2, 16'h0, "abort_rb");
    check("abort_rb.value", 32'(d4_rdata), 32'h0504);

    // randomized traffic against the model
    for (int n = 0; n < 30; n++) begin
      cnt = $urandom_range(0, 5);
      rd = (cnt <= 2) || (cnt == 5);
      wr = (cnt >= 3);
      a = 5'($urandom_range(0, 31));
      d = 16'($urandom);
      do_op(0, rd, wr, a, d, "rand4");
    end

    // latency-1 instance
    for (int k = 0; k < 32; k++) do_op(1, 1'b0, 1'b1, 5'(k), image_word(k), "preload1");
    pulse_reset(1);
    @(negedge clk);
    check_state(1, "rst1");
    do_op(1, 1'b1, 1'b0, 5'd6, 16'h0, "lat1_read6");
    check("lat1_read6.value", 32'(d1_rdata), 32'h0d0c);

    access(1, 1'b0, 1'b1, 5'd9, 16'hbeef, 2, 1'b1, 1'b0, 5'd9, 16'h0, lat, pulses, gap, errs);
    model_op(1, 1'b0, 1'b1, 5'd9, 16'hbeef);
    model_op(1, 1'b1, 1'b0, 5'd9, 16'h0);
    check("lat1_b2b.pulses", 32'(pulses), 32'd2);
    check("lat1_b2b.gap", 32'(gap), 32'(lat_of(1) + 2));
    check("lat1_b2b.value", 32'(d1_rdata), 32'hbeef);
    check_state(1, "lat1_b2b");

    // preset the read counter near the top, then read across saturation
    @(negedge clk);
    force dut1.r_rd_count = 16'hfffa;
    @(posedge clk);
    @(negedge clk);
    release dut1.r_rd_count;
    exp_rd[1] = 65530;
    @(posedge clk);
    @(negedge clk);
    check("sat.preset", 32'(d1_rdc), 32'hfffa);
    for (int n = 0; n < 9; n++) begin
      a = 5'($urandom_range(0, 31));
      do_op(1, 1'b1, 1'b0, a, 16'h0, "sat_read");
    end
    check("sat.final", 32'(d1_rdc), 32'hffff);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
